// File: rtl/hadamard4pt_inv.sv
// Inverse 4-point Walsh-Hadamard transform: parallel coefficients in, serial samples out.
// Optional exactness check enabled by defining HADAMARD_INV_CHECK_EN.
module hadamard4pt_inv #(
    parameter int IW = 10,
    parameter int OW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [IW-1:0] y0,
    input  logic signed [IW-1:0] y1,
    input  logic signed [IW-1:0] y2,
    input  logic signed [IW-1:0] y3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_x,
    output logic [1:0]           out_idx,
    output logic                 out_last,
    output logic                 err
);

    // state  | meaning
    // IDLE   | waiting for a coefficient vector, in_ready high
    // BFLY1  | first butterfly stage registered
    // BFLY2  | second butterfly, divide-by-4, sample registers loaded
    // EMIT   | streaming samples x0..x3 to the consumer
    typedef enum logic [1:0] {IDLE, BFLY1, BFLY2, EMIT} state_t;

    state_t               state;
    logic signed [IW-1:0] c [4];
    logic signed [IW:0]   b [4];
    logic signed [IW+1:0] z [4];
    logic signed [OW-1:0] s [4];

    always_comb begin
        z[0] = {b[0][IW], b[0]} + {b[1][IW], b[1]};
        z[1] = {b[2][IW], b[2]} + {b[3][IW], b[3]};
        z[2] = {b[0][IW], b[0]} - {b[1][IW], b[1]};
        z[3] = {b[2][IW], b[2]} - {b[3][IW], b[3]};
    end

`ifdef HADAMARD_INV_CHECK_EN
    logic chk;

    // Inexact when low bits are set, or when z/4 does not fit the sample width.
    always_comb begin
        chk = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (z[k][1:0] != 2'b00)
                chk = 1'b1;
            if (z[k][IW+1:OW+1] != '0 && z[k][IW+1:OW+1] != '1)
                chk = 1'b1;
        end
    end
`else
    logic unused_zbits;
    assign unused_zbits = ^{z[0][IW+1:OW+2], z[0][1:0], z[1][IW+1:OW+2], z[1][1:0],
                            z[2][IW+1:OW+2], z[2][1:0], z[3][IW+1:OW+2], z[3][1:0]};
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_idx   <= 2'd0;
            out_last  <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                c[k] <= '0;
                b[k] <= '0;
                s[k] <= '0;
            end
`ifdef HADAMARD_INV_CHECK_EN
            err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        c[0]     <= y0;
                        c[1]     <= y1;
                        c[2]     <= y2;
                        c[3]     <= y3;
                        in_ready <= 1'b0;
                        state    <= BFLY1;
`ifdef HADAMARD_INV_CHECK_EN
                        err <= 1'b0;
`endif
                    end
                end
                BFLY1: begin
                    b[0]  <= {c[0][IW-1], c[0]} + {c[1][IW-1], c[1]};
                    b[1]  <= {c[2][IW-1], c[2]} + {c[3][IW-1], c[3]};
                    b[2]  <= {c[0][IW-1], c[0]} - {c[1][IW-1], c[1]};
                    b[3]  <= {c[2][IW-1], c[2]} - {c[3][IW-1], c[3]};
                    state <= BFLY2;
                end
                BFLY2: begin
                    // Bits [OW+1:2] are z>>>2 truncated to OW bits.
                    for (int k = 0; k < 4; k++)
                        s[k] <= z[k][OW+1:2];
                    out_x     <= z[0][OW+1:2];
                    out_idx   <= 2'd0;
                    out_last  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= EMIT;
`ifdef HADAMARD_INV_CHECK_EN
                    err <= chk;
`endif
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_idx == 2'd3) begin
                            out_valid <= 1'b0;
                            out_idx   <= 2'd0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            out_idx  <= out_idx + 2'd1;
                            out_x    <= s[out_idx + 2'd1];
                            out_last <= (out_idx == 2'd2);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hadamard4pt_inv.sv
// Bench for hadamard4pt_inv: matrix-based reference model, per-cycle output compare, directed vectors.
module tb_hadamard4pt_inv;
    localparam int IW = 10;
    localparam int OW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [IW-1:0] y0, y1, y2, y3;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_x;
    logic [1:0]           out_idx;
    logic                 out_last;
    logic                 err;

    hadamard4pt_inv #(.IW(IW), .OW(OW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_idx(out_idx), .out_last(out_last),
        .err(err)
    );

    always #5 clk = ~clk;

`ifdef HADAMARD_INV_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    typedef struct {
        int x;
        int idx;
        bit last;
        bit e;
    } samp_t;

    int    n_chk  = 0;
    int    n_fail = 0;
    samp_t expq[$];
    int    log_x[$];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // x_k = (row_k . y) / 4 with floor division, wrapped to OW bits.
    function automatic void model(input int yv[4], output int xv[4], output bit e);
        int rows[4][4] = '{'{1, 1, 1, 1}, '{1, -1, 1, -1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}};
        int z;
        int q;
        logic signed [OW-1:0] t;
        e = 1'b0;
        for (int k = 0; k < 4; k++) begin
            z = 0;
            for (int j = 0; j < 4; j++)
                z += rows[k][j] * yv[j];
            q = z >>> 2;
            t = q[OW-1:0];
            xv[k] = t;
            if ((z & 3) != 0 || q < -128 || q > 127)
                e = 1'b1;
        end
    endfunction

    // Push the expected sample stream for every accepted vector.
    always @(posedge clk) begin
        int  yv[4];
        int  xv[4];
        bit  ee;
        if (rst) begin
            expq.delete();
        end else if (in_valid && in_ready) begin
            yv[0] = y0; yv[1] = y1; yv[2] = y2; yv[3] = y3;
            model(yv, xv, ee);
            for (int k = 0; k < 4; k++)
                expq.push_back('{x: xv[k], idx: k, last: (k == 3), e: ee && CHECK_ON});
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (expq.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("out_x", out_x, expq[0].x);
                check("out_idx", out_idx, expq[0].idx);
                check("out_last", out_last, expq[0].last);
                check("err", err, expq[0].e);
                check("in_ready_busy", in_ready, 0);
                if (out_ready) begin
                    log_x.push_back(out_x);
                    void'(expq.pop_front());
                end
            end
        end
    end

    task automatic send(input int a, input int b, input int c, input int d,
                        input bit keep, output int waited);
        y0 = IW'(a); y1 = IW'(b); y2 = IW'(c); y3 = IW'(d);
        in_valid = 1'b1;
        waited = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                if (!keep) in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && !out_valid) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("drain_timeout", 0, 1);
    endtask

    task automatic check_log(input string name, input int n, input int exp[8]);
        check({name, "_count"}, log_x.size(), n);
        for (int i = 0; i < n && i < log_x.size(); i++)
            check(name, log_x[i], exp[i]);
        log_x.delete();
    endtask

    initial begin
        int xv[4];
        int yv[4];
        bit ee;
        int w;
        int lat;
        bit seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        y0 = '0; y1 = '0; y2 = '0; y3 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_x", out_x, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Pin the reference model against hand-computed values.
        yv = '{10, -2, -4, 0};
        model(yv, xv, ee);
        check("model_x0", xv[0], 1);
        check("model_x1", xv[1], 2);
        check("model_x2", xv[2], 3);
        check("model_x3", xv[3], 4);
        check("model_exact", ee, 0);
        yv = '{1, 0, 0, 0};
        model(yv, xv, ee);
        check("model_inexact", ee, 1);

        // Basic vector and first-sample latency.
        send(10, -2, -4, 0, 1'b0, w);
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        check("latency", lat, 2);
        drain();
        check_log("seq_basic", 4, '{1, 2, 3, 4, 0, 0, 0, 0});

        send(-512, 0, 0, 0, 1'b0, w);
        drain();
        check_log("seq_min", 4, '{-128, -128, -128, -128, 0, 0, 0, 0});
        send(-2, 510, 0, 0, 1'b0, w);
        drain();
        check_log("seq_alt", 4, '{127, -128, 127, -128, 0, 0, 0, 0});

        // Backpressure: stall 5 cycles on idx 1.
        out_ready = 1'b0;
        send(10, -2, -4, 0, 1'b0, w);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("bp_valid_seen", seen, 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_x", out_x, 2);
            check("stall_idx", out_idx, 1);
            check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        check_log("seq_bp", 4, '{1, 2, 3, 4, 0, 0, 0, 0});

        // Back-to-back with in_valid held high.
        send(10, -2, -4, 0, 1'b1, w);
        send(-10, 2, 4, 0, 1'b0, w);
        check("b2b_wait_cycles", w, 6);
        drain();
        check_log("seq_b2b", 8, '{1, 2, 3, 4, -1, -2, -3, -4});

        // Non-exact coefficients.
        send(1, 0, 0, 0, 1'b0, w);
        drain();
        check_log("seq_inexact", 4, '{0, 0, 0, 0, 0, 0, 0, 0});
        check("err_hold", err, CHECK_ON ? 1 : 0);

        // Reset while emitting idx 2.
        send(10, -2, -4, 0, 1'b0, w);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_idx == 2'd2) seen = 1'b1;
        end
        check("mid_emit_seen", seen, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        check("mrst_out_idx", out_idx, 0);
        check("mrst_err", err, 0);
        log_x.delete();
        send(-10, 2, 4, 0, 1'b0, w);
        drain();
        check_log("seq_after_rst", 4, '{-1, -2, -3, -4, 0, 0, 0, 0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
